// File: rtl/iomem_gpio.sv
// rtl/iomem_gpio.sv - memory-mapped GPIO block with input synchronizers and edge interrupts
//
// Register map (byte address bits [4:2] select the register):
//   0 OUT  rw   pin output values
//   1 DIR  rw   pin output enables, 1 = drive
//   2 IN   ro   synchronized pin inputs
//   3 IEN  rw   per-pin interrupt enable
//   4 PEND w1c  per-pin pending edge flags
//   5 RISE rw   per-pin edge polarity, 1 = rising, 0 = falling
//   6-7        read as zero, writes ignored
//
// Ports:
//   CLKOUT       system clock, rising edge
//   resetn       synchronous active-low reset
//   iomem_valid  bus request valid
//   iomem_ready  one-cycle access-complete pulse
//   iomem_wstrb  byte write strobes, all zero = read
//   iomem_addr   byte address, [31:24] must equal BASE_ADDR
//   iomem_wdata  write data
//   iomem_rdata  read data, held between accesses
//   gpio_in      asynchronous pin inputs
//   gpio_out     OUT register
//   gpio_oe      DIR register
//   irq          registered level interrupt, |(PEND & IEN)

module iomem_gpio #(
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         WIDTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             CLKOUT,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] SEL_OUT  = 3'd0;
    localparam logic [2:0] SEL_DIR  = 3'd1;
    localparam logic [2:0] SEL_IN   = 3'd2;
    localparam logic [2:0] SEL_IEN  = 3'd3;
    localparam logic [2:0] SEL_PEND = 3'd4;
    localparam logic [2:0] SEL_RISE = 3'd5;

    logic             ready_q;
    logic [31:0]      rdata_q;
    logic             irq_q;

    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] ien_q,  ien_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] rise_q, rise_d;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] last_q;

    logic             hit;
    logic [2:0]       sel;
    logic [31:0]      wmask32;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] pend_set;
    logic [WIDTH-1:0] pend_clr;
    logic [31:0]      rd_val;

    // Address bits outside the decode and data lanes above WIDTH are don't-cares.
    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, wmask32};

    always_comb begin
        // Blocking on !ready_q makes a held request complete every other cycle.
        hit     = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
        sel     = iomem_addr[4:2];
        wmask32 = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                   {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        wmask   = wmask32[WIDTH-1:0];
        wbits   = iomem_wdata[WIDTH-1:0];
        in_val  = sync_q[SYNC_STAGES-1];
        // A bit changed and its new level matches the polarity: rising edges
        // end at 1 (RISE=1), falling edges end at 0 (RISE=0).
        edge_sel = (in_val ^ last_q) & ~(in_val ^ rise_q);
        pend_set = edge_sel & ien_q;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_OUT:  rd_val[WIDTH-1:0] = out_q;
            SEL_DIR:  rd_val[WIDTH-1:0] = dir_q;
            SEL_IN:   rd_val[WIDTH-1:0] = in_val;
            SEL_IEN:  rd_val[WIDTH-1:0] = ien_q;
            SEL_PEND: rd_val[WIDTH-1:0] = pend_q;
            SEL_RISE: rd_val[WIDTH-1:0] = rise_q;
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ien_d    = ien_q;
        rise_d   = rise_q;
        pend_clr = '0;
        if (hit) begin
            case (sel)
                SEL_OUT:  out_d    = (out_q  & ~wmask) | (wbits & wmask);
                SEL_DIR:  dir_d    = (dir_q  & ~wmask) | (wbits & wmask);
                SEL_IEN:  ien_d    = (ien_q  & ~wmask) | (wbits & wmask);
                SEL_RISE: rise_d   = (rise_q & ~wmask) | (wbits & wmask);
                SEL_PEND: pend_clr = wbits & wmask;
                default:  pend_clr = '0;
            endcase
        end
        // Applying the set after the clear lets a coincident edge win.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            pend_q  <= '0;
            rise_q  <= '0;
            last_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            ready_q <= hit;
            if (hit) begin
                rdata_q <= rd_val;
            end
            out_q  <= out_d;
            dir_q  <= dir_d;
            ien_q  <= ien_d;
            pend_q <= pend_d;
            rise_q <= rise_d;
            // Registered from current state, so irq follows PEND/IEN by one cycle.
            irq_q  <= |(pend_q & ien_q);
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = out_q;
    assign gpio_oe     = dir_q;
    assign irq         = irq_q;

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 Parameter BASE_ADDR, default 8'h03: iomem_addr[31:24] value that selects this block.
REQ-002 Parameter WIDTH, default 16, legal 1..32: number of GPIO pins.
REQ-003 Parameter SYNC_STAGES, default 2, legal 2..3: input synchronizer depth.
REQ-004 CLKOUT  input  1  system clock; all state changes on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 iomem_valid  input  1  bus request valid.
REQ-007 iomem_ready  output  1  one-cycle access-complete pulse.
REQ-008 iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-009 iomem_addr  input  32  byte address.
REQ-010 iomem_wdata  input  32  write data.
REQ-011 iomem_rdata  output  32  read data, valid while iomem_ready=1.
REQ-012 gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-013 gpio_out  output  WIDTH  pin output values (OUT register).
REQ-014 gpio_oe  output  WIDTH  pin output enables (DIR register; 1 = drive).
REQ-015 irq  output  1  level interrupt = |(PEND & IEN).

Function
REQ-016 Hit = iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR; register select = iomem_addr[4:2].
REQ-017 On hit, iomem_ready SHALL be 1 in the next cycle only, then 0; no two consecutive ready cycles.
REQ-018 Non-hit cycles: iomem_ready=0, no register changes, iomem_rdata holds last value.
REQ-019 Map: 0 OUT (rw), 1 DIR (rw), 2 IN (ro), 3 IEN (rw), 4 PEND (w1c), 5 RISE (rw, 1=rising edge, 0=falling edge per bit); 6-7 read 0, writes ignored, ready still returned.
REQ-020 Read data SHALL be the register value before the same access's write (read-before-write), bits [31:WIDTH] = 0.
REQ-021 Writes apply per byte lane per iomem_wstrb[n]; bits at or above WIDTH ignored.
REQ-022 Writes to IN ignored.
REQ-023 IN = gpio_in after SYNC_STAGES flops; edge detection compares last synchronizer stage with one further delayed flop.
REQ-024 Selected edge on bit i with IEN[i]=1 SHALL set PEND[i] one cycle after that edge appears at the synchronizer output; edges with IEN[i]=0 are discarded.
REQ-025 Simultaneous W1C clear and new edge on the same bit: set wins, PEND[i]=1.
REQ-026 Writing IEN[i] 1->0 leaves PEND[i] unchanged but masks it from irq.
REQ-027 irq SHALL be registered: asserted one cycle after the PEND/IEN update that makes it true.
REQ-028 gpio_out/gpio_oe SHALL update in the cycle iomem_ready is asserted for the write.

Reset
REQ-029 With resetn=0 at a rising edge: OUT, DIR, IEN, PEND, RISE, iomem_ready, iomem_rdata, irq, all synchronizer and edge flops = 0.
REQ-030 Reset during a pending access aborts it; no ready pulse generated for that request.
REQ-031 First access accepted on the first rising edge with resetn=1.

Verification
REQ-032 Write OUT=32'h0000_A5A5, wstrb=4'b0011, then read OUT -> gpio_out=16'hA5A5, rdata=32'h0000_A5A5, ready high exactly 1 cycle per access.
REQ-033 Write DIR=32'hFFFF_00FF wstrb=4'b0001 -> gpio_oe=16'h00FF; read DIR -> 32'h0000_00FF.
REQ-034 gpio_in=16'h0001 from 0, IEN=1, RISE=1 -> IN reads 1 after 2 cycles, PEND[0]=1 cycle 3, irq=1 cycle 4; write PEND=1 -> irq=0 cycle after ready.
REQ-035 RISE[3]=0, IEN[3]=1, gpio_in[3] 1->0 -> PEND=32'h8; rising edge on bit 3 -> no new set.
REQ-036 Edge arriving same cycle as W1C of that bit -> PEND bit remains 1, irq stays 1.
REQ-037 Address 32'h0400_0000 (wrong base) valid held 3 cycles -> ready never asserted; resetn=0 mid-access -> all outputs 0, no ready.
